// File: rtl/axil_pkg.sv
// Shared AXI-Lite widths, response codes and the slave FSM state types.
// Also holds a byte-strobe merge helper.
package axil_pkg;

    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;
    localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_e;
    typedef enum logic {R_IDLE, R_DATA} rd_state_e;

    typedef logic [AXI_ADDR_WIDTH-3:0] reg_idx_t;

    function automatic logic [AXI_DATA_WIDTH-1:0] merge_strb(
        input logic [AXI_DATA_WIDTH-1:0] old_val,
        input logic [AXI_DATA_WIDTH-1:0] new_val,
        input logic [AXI_STRB_WIDTH-1:0] strb
    );
        logic [AXI_DATA_WIDTH-1:0] res;
        res = old_val;
        for (int k = 0; k < AXI_STRB_WIDTH; k++) begin
            if (strb[k]) res[8*k +: 8] = new_val[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axil_if.sv
// AXI-Lite bus bundle (AW, W, B, AR, R) with master and slave views.
interface axil_if;
    import axil_pkg::*;

    logic [AXI_ADDR_WIDTH-1:0] awaddr;
    logic                      awvalid;
    logic                      awready;
    logic [AXI_DATA_WIDTH-1:0] wdata;
    logic [AXI_STRB_WIDTH-1:0] wstrb;
    logic                      wvalid;
    logic                      wready;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;
    logic [AXI_ADDR_WIDTH-1:0] araddr;
    logic                      arvalid;
    logic                      arready;
    logic [AXI_DATA_WIDTH-1:0] rdata;
    logic [1:0]                rresp;
    logic                      rvalid;
    logic                      rready;

    modport m_axil (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport s_axil (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axil_regfile.sv
// Register storage with strobed byte writes, a combinational read mux and
// the address range check shared by both the write and read paths.
module axil_regfile
    import axil_pkg::*;
#(
    parameter int                        REG_COUNT = 16,
    parameter logic [AXI_DATA_WIDTH-1:0] REG_RESET = '0
) (
    input  logic                                     aclk,
    input  logic                                     aresetn,
    input  logic                                     wr_en,
    input  logic [AXI_ADDR_WIDTH-1:0]                wr_addr,
    input  logic [AXI_DATA_WIDTH-1:0]                wr_data,
    input  logic [AXI_STRB_WIDTH-1:0]                wr_strb,
    output logic                                     wr_ok,
    input  logic [AXI_ADDR_WIDTH-1:0]                rd_addr,
    output logic [AXI_DATA_WIDTH-1:0]                rd_data,
    output logic                                     rd_ok,
    output logic [REG_COUNT-1:0][AXI_DATA_WIDTH-1:0] reg_q,
    output logic [REG_COUNT-1:0]                     reg_wr_stb
);

    localparam int       IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam reg_idx_t LIMIT = reg_idx_t'(REG_COUNT);

    logic [REG_COUNT-1:0][AXI_DATA_WIDTH-1:0] regs_q, regs_d;
    logic [REG_COUNT-1:0]                     stb_q, stb_d;
    reg_idx_t                                 wr_idx, rd_idx;
    logic [1:0]                               unused_addr_lsbs;

    // Byte-offset bits play no part in register selection.
    assign wr_idx           = wr_addr[AXI_ADDR_WIDTH-1:2];
    assign rd_idx           = rd_addr[AXI_ADDR_WIDTH-1:2];
    assign unused_addr_lsbs = wr_addr[1:0] ^ rd_addr[1:0];

    assign wr_ok = (wr_idx < LIMIT);
    assign rd_ok = (rd_idx < LIMIT);

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        regs_d = regs_q;
        stb_d  = '0;
        if (wr_en && wr_ok) begin
            regs_d[wr_idx[IDX_W-1:0]] = merge_strb(regs_q[wr_idx[IDX_W-1:0]], wr_data, wr_strb);
            stb_d[wr_idx[IDX_W-1:0]]  = 1'b1;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_ok) rd_data = regs_q[rd_idx[IDX_W-1:0]];
    end

    // NOTE: this storage is software-visible state, so it is reset like any control flop rather than left as an unreset RAM.
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            regs_q <= {REG_COUNT{REG_RESET}};
            stb_q  <= '0;
        end else begin
            regs_q <= regs_d;
            stb_q  <= stb_d;
        end
    end

    assign reg_q      = regs_q;
    assign reg_wr_stb = stb_q;

endmodule

// File: rtl/axil_slave_regs.sv
// AXI-Lite slave front end: independent write and read FSMs driving a bank
// of memory-mapped 32-bit registers held in axil_regfile.
module axil_slave_regs
    import axil_pkg::*;
#(
    parameter int                        REG_COUNT = 16,
    parameter logic [AXI_DATA_WIDTH-1:0] REG_RESET = '0
) (
    input  logic                                     aclk,
    input  logic                                     aresetn,
    axil_if.s_axil                                   s_axil,
    output logic [REG_COUNT-1:0][AXI_DATA_WIDTH-1:0] reg_q,
    output logic [REG_COUNT-1:0]                     reg_wr_stb
);

    wr_state_e                 wr_state_q, wr_state_d;
    rd_state_e                 rd_state_q, rd_state_d;
    logic                      awready_q, awready_d, wready_q, wready_d;
    logic                      aw_have_q, aw_have_d, w_have_q, w_have_d;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [AXI_STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                      bvalid_q, bvalid_d;
    logic [1:0]                bresp_q, bresp_d;
    logic                      arready_q, arready_d;
    logic                      rvalid_q, rvalid_d;
    logic [1:0]                rresp_q, rresp_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                      aw_hs, w_hs, ar_hs;
    logic                      wr_en, wr_ok, rd_ok;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr;
    logic [AXI_DATA_WIDTH-1:0] wr_data, rd_data;
    logic [AXI_STRB_WIDTH-1:0] wr_strb;

    assign aw_hs = s_axil.awvalid && awready_q;
    assign w_hs  = s_axil.wvalid  && wready_q;
    assign ar_hs = s_axil.arvalid && arready_q;

    axil_regfile #(
        .REG_COUNT (REG_COUNT),
        .REG_RESET (REG_RESET)
    ) u_regfile (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_strb    (wr_strb),
        .wr_ok      (wr_ok),
        .rd_addr    (s_axil.araddr),
        .rd_data    (rd_data),
        .rd_ok      (rd_ok),
        .reg_q      (reg_q),
        .reg_wr_stb (reg_wr_stb)
    );

    // A beat arriving on the completing edge is used directly; an earlier one comes from its latch.
    always_comb begin
        wr_state_d = wr_state_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        aw_have_d  = aw_have_q;
        w_have_d   = w_have_q;
        awaddr_d   = aw_hs ? s_axil.awaddr : awaddr_q;
        wdata_d    = w_hs  ? s_axil.wdata  : wdata_q;
        wstrb_d    = w_hs  ? s_axil.wstrb  : wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_en      = 1'b0;
        wr_addr    = awaddr_d;
        wr_data    = wdata_d;
        wr_strb    = wstrb_d;

        unique case (wr_state_q)
            W_IDLE: begin
                aw_have_d = aw_have_q || aw_hs;
                w_have_d  = w_have_q  || w_hs;
                if (aw_have_d && w_have_d) begin
                    wr_en      = 1'b1;
                    bvalid_d   = 1'b1;
                    bresp_d    = wr_ok ? RESP_OKAY : RESP_SLVERR;
                    awready_d  = 1'b0;
                    wready_d   = 1'b0;
                    aw_have_d  = 1'b0;
                    w_have_d   = 1'b0;
                    wr_state_d = W_RESP;
                end else begin
                    awready_d = !aw_have_d;
                    wready_d  = !w_have_d;
                end
            end
            W_RESP: begin
                if (s_axil.bready) begin
                    bvalid_d   = 1'b0;
                    awready_d  = 1'b1;
                    wready_d   = 1'b1;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;

        unique case (rd_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    arready_d  = 1'b0;
                    rvalid_d   = 1'b1;
                    rdata_d    = rd_data;
                    rresp_d    = rd_ok ? RESP_OKAY : RESP_SLVERR;
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axil.rready) begin
                    rvalid_d   = 1'b0;
                    arready_d  = 1'b1;
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            aw_have_q  <= 1'b0;
            w_have_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            aw_have_q  <= aw_have_d;
            w_have_q   <= w_have_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

    assign s_axil.awready = awready_q;
    assign s_axil.wready  = wready_q;
    assign s_axil.bvalid  = bvalid_q;
    assign s_axil.bresp   = bresp_q;
    assign s_axil.arready = arready_q;
    assign s_axil.rvalid  = rvalid_q;
    assign s_axil.rresp   = rresp_q;
    assign s_axil.rdata   = rdata_q;

endmodule

// File: tb/tb_axil_slave_regs.sv
// Directed bench for axil_slave_regs: hand-computed expectations for reset,
// write ordering, byte strobes, range errors, read/write collision and mid-transaction reset.
module tb_axil_slave_regs;
    import axil_pkg::*;

    localparam int REG_COUNT = 16;

    logic aclk = 1'b0;
    logic aresetn;
    logic [REG_COUNT-1:0][31:0] reg_q;
    logic [REG_COUNT-1:0]       reg_wr_stb;
    logic [REG_COUNT-1:0][31:0] exp_regs;

    int n_tests = 0;
    int n_fail  = 0;

    axil_if bus ();

    axil_slave_regs #(
        .REG_COUNT (REG_COUNT),
        .REG_RESET ('0)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .s_axil     (bus),
        .reg_q      (reg_q),
        .reg_wr_stb (reg_wr_stb)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic bv, output logic [1:0] resp, output logic [REG_COUNT-1:0] stb);
        bus.awaddr  = addr;
        bus.awvalid = 1'b1;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.wvalid  = 1'b1;
        tick();
        bv   = bus.bvalid;
        resp = bus.bresp;
        stb  = reg_wr_stb;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b1;
        tick();
        bus.bready  = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic rv, output logic [31:0] data,
                           output logic [1:0] resp);
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        tick();
        rv   = bus.rvalid;
        data = bus.rdata;
        resp = bus.rresp;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
        tick();
        bus.rready  = 1'b0;
    endtask

    initial begin
        logic                 bv, rv;
        logic [1:0]           resp;
        logic [31:0]          data;
        logic [REG_COUNT-1:0] stb;

        aresetn     = 1'b0;
        bus.awaddr  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        exp_regs    = '0;

        repeat (3) tick();
        check("rst_awready", bus.awready, 1'b0);
        check("rst_arready", bus.arready, 1'b0);
        check("rst_bvalid",  bus.bvalid,  1'b0);
        check("rst_rvalid",  bus.rvalid,  1'b0);
        check("rst_rdata",   bus.rdata,   32'h0);
        check("rst_regs",    reg_q,       exp_regs);

        aresetn = 1'b1;
        check("rel_ready_low", {bus.awready, bus.wready, bus.arready}, 3'b000);
        tick();
        check("rel_ready_high", {bus.awready, bus.wready, bus.arready}, 3'b111);

        // AW and W on the same edge to register 2.
        bus.awaddr = 32'h08; bus.awvalid = 1'b1;
        bus.wdata = 32'hDEAD_BEEF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        exp_regs[2] = 32'hDEAD_BEEF;
        check("w1_bvalid", bus.bvalid, 1'b1);
        check("w1_bresp",  bus.bresp,  RESP_OKAY);
        check("w1_stb",    reg_wr_stb, 16'h0004);
        check("w1_regs",   reg_q,      exp_regs);
        check("w1_ready_low", {bus.awready, bus.wready}, 2'b00);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        check("w1_bvalid_clr", bus.bvalid, 1'b0);
        check("w1_stb_clr",    reg_wr_stb, 16'h0);
        check("w1_ready_back", {bus.awready, bus.wready}, 2'b11);
        do_read(32'h08, rv, data, resp);
        check("r1_rvalid", rv,   1'b1);
        check("r1_rdata",  data, 32'hDEAD_BEEF);
        check("r1_rresp",  resp, RESP_OKAY);

        // W three cycles ahead of AW, register 5.
        bus.wdata = 32'h1234_5678; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        check("wfirst_wready", bus.wready, 1'b0);
        tick(); tick();
        check("wfirst_no_b",    bus.bvalid, 1'b0);
        check("wfirst_no_stb",  reg_wr_stb, 16'h0);
        check("wfirst_regs",    reg_q,      exp_regs);
        bus.awaddr = 32'h14; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        exp_regs[5] = 32'h1234_5678;
        check("wfirst_bvalid", bus.bvalid, 1'b1);
        check("wfirst_stb",    reg_wr_stb, 16'h0020);
        check("wfirst_regs2",  reg_q,      exp_regs);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bhold_valid", bus.bvalid, 1'b1);
            check("bhold_resp",  bus.bresp,  RESP_OKAY);
            check("bhold_stb",   reg_wr_stb, 16'h0);
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        check("wfirst_bclr", bus.bvalid, 1'b0);

        // AW three cycles ahead of W, register 6.
        bus.awaddr = 32'h18; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        check("awfirst_awready", bus.awready, 1'b0);
        tick(); tick();
        check("awfirst_no_b", bus.bvalid, 1'b0);
        bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        exp_regs[6] = 32'hCAFE_F00D;
        check("awfirst_bvalid", bus.bvalid, 1'b1);
        check("awfirst_stb",    reg_wr_stb, 16'h0040);
        check("awfirst_regs",   reg_q,      exp_regs);
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;

        // Byte strobes on register 1.
        do_write(32'h04, 32'h1122_3344, 4'hF, bv, resp, stb);
        do_write(32'h04, 32'hAABB_CCDD, 4'h5, bv, resp, stb);
        exp_regs[1] = 32'h11BB_33DD;
        check("strb_stb", stb, 16'h0002);
        do_read(32'h04, rv, data, resp);
        check("strb_rdata", data, 32'h11BB_33DD);

        // wstrb of zero: OKAY, strobe pulses, contents untouched.
        do_write(32'h08, 32'h0BAD_0BAD, 4'h0, bv, resp, stb);
        check("strb0_resp", resp, RESP_OKAY);
        check("strb0_stb",  stb,  16'h0004);
        check("strb0_regs", reg_q, exp_regs);

        // Last in-range register, and address low bits ignored on read.
        do_write(32'h3C, 32'h0F0F_0F0F, 4'hF, bv, resp, stb);
        exp_regs[15] = 32'h0F0F_0F0F;
        check("top_resp", resp, RESP_OKAY);
        check("top_stb",  stb,  16'h8000);
        do_read(32'h0B, rv, data, resp);
        check("lsb_rdata", data, 32'hDEAD_BEEF);

        // Out-of-range write and read at 0x40.
        do_write(32'h40, 32'hFFFF_FFFF, 4'hF, bv, resp, stb);
        check("oor_bvalid", bv,   1'b1);
        check("oor_bresp",  resp, RESP_SLVERR);
        check("oor_stb",    stb,  16'h0);
        check("oor_regs",   reg_q, exp_regs);
        do_read(32'h40, rv, data, resp);
        check("oor_rresp", resp, RESP_SLVERR);
        check("oor_rdata", data, 32'h0);

        // Same-edge write and read of register 3.
        bus.awaddr = 32'h0C; bus.awvalid = 1'b1;
        bus.wdata = 32'h5; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        bus.araddr = 32'h0C; bus.arvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0; bus.bready = 1'b1;
        exp_regs[3] = 32'h5;
        check("coll_rvalid", bus.rvalid, 1'b1);
        check("coll_rdata",  bus.rdata,  32'h0);
        check("coll_regs",   reg_q,      exp_regs);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rhold_valid", bus.rvalid, 1'b1);
            check("rhold_rdata", bus.rdata,  32'h0);
        end
        bus.bready = 1'b0;
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        check("coll_rclr", bus.rvalid, 1'b0);
        do_read(32'h0C, rv, data, resp);
        check("coll_reread", data, 32'h5);

        // Reset while B and R are both outstanding.
        bus.awaddr = 32'h10; bus.awvalid = 1'b1;
        bus.wdata = 32'h77; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        bus.araddr = 32'h08; bus.arvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        check("mid_bvalid", {bus.bvalid, bus.rvalid}, 2'b11);
        aresetn = 1'b0;
        tick();
        exp_regs = '0;
        check("mid_drop",  {bus.bvalid, bus.rvalid}, 2'b00);
        check("mid_regs",  reg_q, exp_regs);
        aresetn = 1'b1;
        check("mid_ready_low", {bus.awready, bus.wready, bus.arready}, 3'b000);
        tick();
        check("mid_ready_high", {bus.awready, bus.wready, bus.arready}, 3'b111);
        do_read(32'h04, rv, data, resp);
        check("mid_reread", data, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axil_slave_regs.md
# axil_slave_regs

AXI-Lite responder that terminates the `axil_if` bus with a bank of memory-mapped 32-bit control/status registers. It is the slave-side counterpart of the team's AXI-Lite master, and is used by any block that needs software-visible configuration. It accepts AW and W independently in any order and honours byte strobes. It returns SLVERR for out-of-range addresses and exports the register contents plus per-register write pulses to the surrounding logic.

## Interface
Parameters:
- `REG_COUNT`, default 16: number of 32-bit registers, 1..256; need not be a power of two.
- `REG_RESET`, default `'0`: reset value loaded into every register.

Ports:
- `aclk`: input, 1 bit. Single clock.
- `aresetn`: input, 1 bit. Reset is synchronous and active-low.
- `s_axil`: `axil_if.s_axil` modport. Full AXI-Lite slave (AW, W, B, AR, R channels).
- `reg_q`: output, `[REG_COUNT-1:0][AXI_DATA_WIDTH-1:0]`. Current register contents.
- `reg_wr_stb`: output, `[REG_COUNT-1:0]`. One-cycle pulse on the register written.

## Operation
- Address decode:
  - index = addr >> 2; bits [1:0] are ignored.
  - index >= `REG_COUNT` is out of range: response SLVERR (2'b10), no register changes, no strobe, `rdata` = 0.
  - In-range accesses respond OKAY (2'b00).
- Write byte lane k updates only when `wstrb[k]` = 1. `wstrb` = 0 is a legal no-op write: OKAY, and the strobe still pulses.
- Write FSM:
  - W_IDLE: `awready` = `wready` = 1.
    - An AW handshake latches `awaddr` and drops `awready` next cycle.
    - A W handshake latches `wdata`/`wstrb` and drops `wready` next cycle.
    - Either order is allowed, as is the same edge.
  - At the edge where the second of AW/W completes, go to W_RESP:
    - register written that edge;
    - `bvalid` <= 1, `bresp` set;
    - `reg_wr_stb[index]` high for exactly the next cycle.
  - W_RESP: hold `bvalid`/`bresp` stable until `bready`. On the handshake: `bvalid` <= 0, `awready` <= `wready` <= 1, go to W_IDLE.
- Read FSM:
  - R_IDLE: `arready` = 1. On an AR handshake: `arready` <= 0, `rdata`/`rresp` <= decode of `araddr`, `rvalid` <= 1, go to R_DATA.
  - R_DATA: hold `rvalid`/`rdata`/`rresp` stable until `rready`. On the handshake: `rvalid` <= 0, `arready` <= 1, go to R_IDLE.
- The read and write FSMs are fully independent.

## Timing
- Reset values (during reset and on the first cycle after):
  - `awready`, `wready`, `arready`, `bvalid`, `rvalid` = 0; `bresp`, `rresp`, `rdata` = 0.
  - `reg_q` = `REG_RESET`; `reg_wr_stb` = 0.
- The readies rise on the first edge after `aresetn` goes high.
- Write latency:
  - AW+W on the same edge gives `bvalid` the next cycle.
  - `reg_q` reflects the new value in that same cycle as `bvalid`.
  - With `bready` held high, the next AW/W can be accepted 2 cycles after the data edge.
- Read latency: `rvalid` in the cycle after the AR handshake. With `rready` high, the next AR can be accepted 2 cycles after the previous one.
- Same-edge read and write of the same register: the read returns the pre-write value.
- Reset mid-transaction: outstanding B/R are dropped without a response, and registers reload `REG_RESET`.
- All outputs are registered; there are no combinational valid-to-ready paths.

## Structure
- Package `axil_pkg`:
  - `AXI_ADDR_WIDTH` = 32, `AXI_DATA_WIDTH` = 32;
  - `RESP_OKAY` = 2'b00, `RESP_SLVERR` = 2'b10;
  - write and read FSM state enums.
- Sub-module `axil_regfile` holds storage, strobed byte writes, read mux and range check. `axil_slave_regs` holds both FSMs and the channel registers.

## Test plan
- Reset then write 0x0000_0008 = 0xDEAD_BEEF, `wstrb` 0xF, AW and W on the same cycle:
  - `bvalid` one cycle later, `bresp` 0;
  - `reg_wr_stb[2]` pulses for one cycle;
  - reading 0x08 returns 0xDEAD_BEEF with `rresp` 0.
- W presented 3 cycles before AW (and the reverse): exactly one write, `bvalid` only after both handshakes; `bready` held low 4 cycles keeps `bvalid`/`bresp` stable.
- Register 1 = 0x1122_3344, then write 0xAABB_CCDD with `wstrb` 0x5: readback is 0x11BB_33DD.
- Write and read at 0x40 with `REG_COUNT` 16:
  - `bresp` = `rresp` = 2'b10, `rdata` 0;
  - no strobe, and all `reg_q` unchanged.
- Same-edge write 0x5 and read of register 3 (holding 0x0): `rdata` 0x0, a subsequent read returns 0x5. `rready` held low 3 cycles keeps `rvalid`/`rdata` stable.
- Assert `aresetn` low while `bvalid` is pending:
  - `bvalid` drops and `reg_q` returns to `REG_RESET`;
  - the readies rise one cycle after release.
